// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide sequencer.
package muldiv_pkg;
  localparam int WIDTH = 19;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DIV0_QUO = 19'h7FFFF;
endpackage

// File: rtl/muldiv_if.sv
// E-stage request / result bundle between the pipeline control and muldiv_seq.
interface muldiv_if;
  import muldiv_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             flushE;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, srcA, srcB, flushE,
                  input  stall, busy, done, result);
  modport slave  (input  start, op, srcA, srcB, flushE,
                  output stall, busy, done, result);
endinterface

// File: rtl/muldiv_dp.sv
// Shift-add multiplier and restoring divider, one bit per step strobe.
// Outputs are the post-step values so the final result is visible in the last step cycle.
module muldiv_dp
  import muldiv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quo_o,
  output logic [WIDTH-1:0]   rem_o
);
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q, quo_q;
  logic [WIDTH:0]     rem_q;

  logic [WIDTH:0]     sum, trial, rem_step;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   quo_step;
  logic               unused_rem_msb;

  // acc = {partial product, remaining multiplier bits}; shifts right each step
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign acc_step = {sum, acc_q[WIDTH-1:1]};

  assign trial    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign diff     = {1'b0, trial} - {2'b00, opnd_q};
  assign rem_step = diff[WIDTH+1] ? trial : diff[WIDTH:0];
  assign quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};

  // remainder < divisor < 2^19, so the top bit of the stored remainder is always 0
  assign unused_rem_msb = rem_q[WIDTH];

  assign prod_o = acc_step;
  assign quo_o  = quo_step;
  assign rem_o  = rem_step[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      opnd_q <= is_div_i ? b_i : a_i;
      acc_q  <= {{WIDTH{1'b0}}, b_i};
      quo_q  <= a_i;
      rem_q  <= '0;
    end else if (step_i) begin
      if (is_div_i) begin
        quo_q <= quo_step;
        rem_q <= rem_step;
      end else begin
        acc_q <= acc_step;
      end
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/MULH/DIV/REM sequencer for the E stage: FSM, counter, stall/done.
// Define MULDIV_SIGNED_EN for two's complement operands (magnitude + sign fixup).
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  state_t             state_q, state_d;
  logic [4:0]         count_q, count_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               accept, div0, load, step, is_div;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, quo_fx, rem_fx, calc_res;
  logic [2*WIDTH-1:0] prod, prod_fx;

  assign accept = (state_q == IDLE) && bus.start && !bus.flushE;
  assign div0   = bus.op[1] && (bus.srcB == '0);
  assign is_div = (state_q == IDLE) ? bus.op[1] : op_q[1];

`ifdef MULDIV_SIGNED_EN
  logic sa_q, sb_q;

  assign a_mag = bus.srcA[WIDTH-1] ? -bus.srcA : bus.srcA;
  assign b_mag = bus.srcB[WIDTH-1] ? -bus.srcB : bus.srcB;

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (load) begin
      sa_q <= bus.srcA[WIDTH-1];
      sb_q <= bus.srcB[WIDTH-1];
    end
  end

  // -2^18 / -1 falls out naturally: magnitude 2^18 re-reads as 19'h40000
  assign prod_fx = (sa_q ^ sb_q) ? -prod : prod;
  assign quo_fx  = (sa_q ^ sb_q) ? -quo  : quo;
  assign rem_fx  = sa_q ? -rem : rem;
`else
  assign a_mag   = bus.srcA;
  assign b_mag   = bus.srcB;
  assign prod_fx = prod;
  assign quo_fx  = quo;
  assign rem_fx  = rem;
`endif

  muldiv_dp u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (step),
    .is_div_i (is_div),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .prod_o   (prod),
    .quo_o    (quo),
    .rem_o    (rem)
  );

  always_comb begin
    case (op_q)
      OP_MUL:  calc_res = prod_fx[WIDTH-1:0];
      OP_MULH: calc_res = prod_fx[2*WIDTH-1:WIDTH];
      OP_DIV:  calc_res = quo_fx;
      default: calc_res = rem_fx;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        load    = 1'b1;
        count_d = 5'd18;
        if (div0) begin
          state_d  = DONE;
          result_d = bus.op[0] ? bus.srcA : DIV0_QUO;
        end else begin
          state_d  = CALC;
        end
      end
      CALC: if (bus.flushE) begin
        state_d = IDLE;
      end else begin
        step    = 1'b1;
        count_d = count_q - 5'd1;
        if (count_q == 5'd0) begin
          state_d  = DONE;
          result_d = calc_res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      if (load) op_q <= bus.op;
    end
  end

  assign bus.stall  = accept || (state_q == CALC);
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed vector table plus hand-written flush/reset/ignored-start sequences for muldiv_seq.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  muldiv_if bus ();

  muldiv_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
    int               done_cyc;
    string            nm;
  } vec_t;

`ifdef MULDIV_SIGNED_EN
  localparam logic [WIDTH-1:0] E_MULH_M1 = 19'h00000, E_DIV_N7 = 19'h7FFFD, E_REM_N7 = 19'h7FFFF,
                               E_DIV_OV  = 19'h40000, E_REM_OV = 19'h00000, E_MULH_BIG = 19'h7FFFE,
                               E_REM_M1  = 19'h7FFFF;
`else
  localparam logic [WIDTH-1:0] E_MULH_M1 = 19'h7FFFE, E_DIV_N7 = 19'h3FFFC, E_REM_N7 = 19'h00001,
                               E_DIV_OV  = 19'h00000, E_REM_OV = 19'h40000, E_MULH_BIG = 19'h00002,
                               E_REM_M1  = 19'h00001;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start in cycle 0, watch 30 cycles for stall/done behaviour
  task automatic run_op(input vec_t v);
    int done_cyc = -1, ndone = 0, nstall = 0, last_stall = -1;
    logic [WIDTH-1:0] res = '0;
    tick();
    bus.start = 1'b1; bus.op = v.op; bus.srcA = v.a; bus.srcB = v.b;
    #1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin tick(); bus.start = 1'b0; #1; end
      if (bus.stall) begin nstall++; last_stall = c; end
      if (bus.done) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = c; res = bus.result; end
      end
    end
    chk({v.nm, "_result"}, res, v.exp);
    chk({v.nm, "_done_cyc"}, done_cyc, v.done_cyc);
    chk({v.nm, "_done_cnt"}, ndone, 1);
    chk({v.nm, "_stall_cnt"}, nstall, v.done_cyc);
    chk({v.nm, "_stall_last"}, last_stall, v.done_cyc - 1);
    chk({v.nm, "_hold"}, bus.result, v.exp);
  endtask

  initial begin
    vec_t vecs[$];
    int ndone, done_cyc, hold_bad;
    logic [WIDTH-1:0] res;

    bus.start = 1'b0; bus.op = OP_MUL; bus.srcA = '0; bus.srcB = '0; bus.flushE = 1'b0;

    vecs.push_back('{OP_MUL,  19'd1234,   19'd56,     19'd69104,  20, "mul_basic"});
    vecs.push_back('{OP_MULH, 19'h7FFFF,  19'h7FFFF,  E_MULH_M1,  20, "mulh_ones"});
    vecs.push_back('{OP_MUL,  19'h7FFFF,  19'd2,      19'h7FFFE,  20, "mul_wrap"});
    vecs.push_back('{OP_MULH, 19'h40000,  19'd4,      E_MULH_BIG, 20, "mulh_msb"});
    vecs.push_back('{OP_DIV,  19'd100,    19'd7,      19'd14,     20, "div_100_7"});
    vecs.push_back('{OP_REM,  19'd100,    19'd7,      19'd2,      20, "rem_100_7"});
    vecs.push_back('{OP_DIV,  19'h7FFF9,  19'd2,      E_DIV_N7,   20, "div_n7_2"});
    vecs.push_back('{OP_REM,  19'h7FFF9,  19'd2,      E_REM_N7,   20, "rem_n7_2"});
    vecs.push_back('{OP_DIV,  19'h40000,  19'h7FFFF,  E_DIV_OV,   20, "div_ovf"});
    vecs.push_back('{OP_REM,  19'h40000,  19'h7FFFF,  E_REM_OV,   20, "rem_ovf"});
    vecs.push_back('{OP_DIV,  19'h7FFFF,  19'd1,      19'h7FFFF,  20, "div_by1"});
    vecs.push_back('{OP_REM,  19'h7FFFF,  19'd3,      E_REM_M1,   20, "rem_m1_3"});
    vecs.push_back('{OP_DIV,  19'd500,    19'd0,      19'h7FFFF,  1,  "div_by0"});
    vecs.push_back('{OP_REM,  19'd500,    19'd0,      19'd500,    1,  "rem_by0"});

    tick(); tick();
    chk("rst_stall", bus.stall, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // flush mid-DIV: no done, result holds, restart in the IDLE cycle
    run_op('{OP_DIV, 19'd100, 19'd7, 19'd14, 20, "pre_flush"});
    ndone = 0; done_cyc = -1; hold_bad = 0; res = '0;
    tick();
    bus.start = 1'b1; bus.op = OP_DIV; bus.srcA = 19'd1000; bus.srcB = 19'd3;
    #1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      bus.start  = (c == 6);
      bus.flushE = (c == 5);
      if (c == 6) begin bus.op = OP_MUL; bus.srcA = 19'd3; bus.srcB = 19'd5; end
      #1;
      if (c == 5) chk("flush_stall_k", bus.stall, 1);
      if (c == 6) chk("flush_idle", bus.busy, 0);
      if (c < 26 && bus.result !== 19'd14) hold_bad++;
      if (bus.done) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = c; res = bus.result; end
      end
    end
    chk("flush_hold", hold_bad, 0);
    chk("flush_done_cnt", ndone, 1);
    chk("flush_restart_cyc", done_cyc, 26);
    chk("flush_restart_res", res, 19'd15);

    // start together with flushE in IDLE is dropped
    tick();
    bus.start = 1'b1; bus.flushE = 1'b1; bus.op = OP_MUL; bus.srcA = 19'd2; bus.srcB = 19'd2;
    #1;
    chk("flush_start_stall", bus.stall, 0);
    tick();
    bus.start = 1'b0; bus.flushE = 1'b0;
    #1;
    chk("flush_start_busy", bus.busy, 0);

    // synchronous reset in cycle 10 of a MUL
    ndone = 0;
    tick();
    bus.start = 1'b1; bus.op = OP_MUL; bus.srcA = 19'd1234; bus.srcB = 19'd56;
    #1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      bus.start = 1'b0;
      rst = (c == 10);
      #1;
    end
    chk("midrst_stall", bus.stall, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_result", bus.result, 0);
    for (int c = 12; c <= 35; c++) begin
      tick();
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    // start pulses in CALC and DONE are ignored
    ndone = 0; done_cyc = -1; res = '0;
    tick();
    bus.start = 1'b1; bus.op = OP_MUL; bus.srcA = 19'd10; bus.srcB = 19'd10;
    #1;
    for (int c = 1; c <= 44; c++) begin
      tick();
      bus.start = (c == 5) || (c == 20);
      #1;
      if (c == 20) chk("done_start_stall", bus.stall, 0);
      if (c == 21) chk("post_done_idle", bus.busy, 0);
      if (bus.done) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = c; res = bus.result; end
      end
    end
    chk("ignore_done_cnt", ndone, 1);
    chk("ignore_done_cyc", done_cyc, 20);
    chk("ignore_result", res, 19'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the 19-bit pipelined CPU's execute stage. It accepts a MUL/MULH/DIV/REM request from E-stage control and runs a one-bit-per-cycle shift-add multiplier or restoring divider. While the operation runs, it holds the pipeline through a stall request to the hazard unit, then presents the 19-bit result for one write-back cycle.

## Interface
- WIDTH, 19, operand/result width; only 19 is supported.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request from E stage, sampled only in IDLE.
- op  input  2  operation: 00 MUL (low half), 01 MULH (high half), 10 DIV, 11 REM.
- srcA  input  19  multiplicand or dividend.
- srcB  input  19  multiplier or divisor.
- flushE  input  1  E-stage flush; aborts any operation.
- stall  output  1  stall request to the hazard unit.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle result-valid pulse.
- result  output  19  registered result; holds until the next completion.

## Operation
- Reset: state IDLE; busy=0, done=0, stall=0, result=0, all internal registers 0.
- States:
  - IDLE: on start & !flushE, latch op and operands and load count=18. Go to DONE if a DIV/REM has srcB==0; otherwise go to CALC.
  - CALC: one iteration per cycle, count decrements. At count==0, write result and go to DONE. On flushE, go to IDLE with no done pulse and result unchanged.
  - DONE: done=1 for one cycle, then IDLE.
- MUL datapath:
  - 38-bit accumulator; shift-add over 19 multiplier bits.
  - MUL returns product[18:0]; MULH returns product[37:19].
- DIV/REM datapath:
  - Restoring division: 19-bit quotient register, 20-bit partial remainder.
  - Quotient and remainder are truncating.
- Divide by zero bypasses CALC:
  - DIV result = 19'h7FFFF.
  - REM result = srcA.
- stall = (IDLE & start & !flushE) | CALC. It is low in DONE, so the pipeline advances and captures result in that cycle.
- start outside IDLE is ignored. The E stage must hold start low while stall is asserted by this block.

## Timing
- start high in cycle 0 gives:
  - CALC in cycles 1–19;
  - DONE in cycle 20 (done=1, result valid);
  - IDLE in cycle 21.
- stall is high in cycles 0–19.
- Divide by zero: DONE in cycle 1; stall high in cycle 0 only.
- result updates on the edge entering DONE. It is stable from the DONE cycle until the next completion.
- flushE in CALC cycle k gives IDLE in cycle k+1; stall stays high during cycle k.
- flushE together with start in IDLE: start is ignored, stall=0.
- rst in any state gives IDLE and the reset values on the next edge. It takes priority over start and flushE.
- start in the DONE cycle is ignored. A back-to-back operation is accepted in cycle 21 at the earliest.

## Configuration
- MULDIV_SIGNED_EN defined:
  - Operands are two's complement. Magnitudes are taken in IDLE and signs are fixed up when result is written.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Overflow case −2^18 / −1: DIV = 19'h40000, REM = 0.
  - Fixed latency is unchanged.
- MULDIV_SIGNED_EN undefined:
  - Pure unsigned arithmetic; no abs/fixup logic is synthesised.

## Structure
- Package muldiv_pkg holds:
  - WIDTH constant;
  - op encodings (OP_MUL, OP_MULH, OP_DIV, OP_REM);
  - state enum (IDLE, CALC, DONE);
  - the divide-by-zero quotient constant.
- Top muldiv_seq holds the FSM, counter, stall/done logic and the signed fixup.
- Sub-module muldiv_dp holds:
  - accumulator/remainder/quotient shift registers;
  - per-cycle add/subtract step, driven by load, step and is_div strobes.

## Test plan
- MUL 1234 × 56, start in cycle 0 → done in cycle 20, result = 69104; stall high in cycles 0–19 only.
- MULH 19'h7FFFF × 19'h7FFFF:
  - unsigned → 19'h7FFFE;
  - with MULH_SIGNED... i.e. with MULDIV_SIGNED_EN (−1 × −1) → 19'h00000.
- DIV and REM 100 / 7 → 14 and 2. With MULDIV_SIGNED_EN, −7 / 2 (19'h7FFF9) → DIV 19'h7FFFD, REM 19'h7FFFF.
- DIV 500 / 0 → done in cycle 1, result 19'h7FFFF. REM 500 / 0 → 500.
- DIV started in cycle 0, flushE in cycle 5 → IDLE in cycle 6, no done pulse, result keeps its previous value. A new start in cycle 6 completes in cycle 26.
- rst in cycle 10 of a MUL → all outputs 0 next cycle. start pulses during CALC and DONE are ignored; only one done pulse per accepted start.
